// File: rtl/router_out_arb_if.sv
// Merged output byte stream of router_out_arb toward a ready/valid sink.
// The master drives data and tags; the slave returns m_ready.
interface router_out_arb_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_sop;
  logic       m_eop;
  logic [1:0] m_port;
  logic       m_err;

  modport master (output m_data, m_valid, m_sop, m_eop, m_port, m_err, input m_ready);
  modport slave  (input m_data, m_valid, m_sop, m_eop, m_port, m_err, output m_ready);
endinterface

// File: rtl/router_out_arb.sv
// Round-robin merge of three router FIFOs into one packet stream; optional parity check via ROUTER_ARB_PARITY_CHK_EN.
// Latency: header pop 1 cycle after request in IDLE, header on m_data 3 cycles after; 1 byte/cycle sustained.
// Backpressure: FIFO pops stop while buffered plus in-flight bytes reach 3; never switches port mid-packet.
module router_out_arb (
  input  logic       clock,
  input  logic       resetn,
  input  logic       vld_out_0,
  input  logic       vld_out_1,
  input  logic       vld_out_2,
  input  logic [7:0] data_out_0,
  input  logic [7:0] data_out_1,
  input  logic [7:0] data_out_2,
  output logic       read_enb_0,
  output logic       read_enb_1,
  output logic       read_enb_2,
  output logic       busy_arb,
  router_out_arb_if.master m
);

  typedef enum logic [1:0] {IDLE, HDR, HLEN, BODY} state_t;

`ifdef ROUTER_ARB_PARITY_CHK_EN
  typedef struct packed {
    logic       err;
    logic       eop;
    logic       sop;
    logic [1:0] port;
    logic [7:0] dat;
  } ent_t;
`else
  typedef struct packed {
    logic       eop;
    logic       sop;
    logic [1:0] port;
    logic [7:0] dat;
  } ent_t;
`endif

  state_t     state;
  logic [1:0] gnt;
  logic [1:0] ptr;
  logic [6:0] rem;
  logic       rd_pend;
  logic       rd_sop;
  logic       rd_eop;

  ent_t       buf_q [3];
  logic [1:0] wr_idx;
  logic [1:0] rd_idx;
  logic [1:0] cnt;

  logic [2:0] req;
  logic [1:0] pick;
  logic [1:0] next_ptr;
  logic       vld_gnt;
  logic [7:0] rd_dat;
  logic [5:0] hdr_len;
  logic       credit;
  logic       rd_fire;
  logic       last_pop;
  logic       push;
  logic       pop;
  ent_t       push_ent;
  ent_t       head;

  assign req = {vld_out_2, vld_out_1, vld_out_0};

  always_comb begin
    pick = 2'd0;
    case (ptr)
      2'd1:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd2:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    vld_gnt = 1'b0;
    rd_dat  = 8'h00;
    case (gnt)
      2'd0:    begin vld_gnt = vld_out_0; rd_dat = data_out_0; end
      2'd1:    begin vld_gnt = vld_out_1; rd_dat = data_out_1; end
      2'd2:    begin vld_gnt = vld_out_2; rd_dat = data_out_2; end
      default: begin vld_gnt = 1'b0;      rd_dat = 8'h00;      end
    endcase
  end

  assign hdr_len  = rd_dat[7:2];
  assign next_ptr = (gnt == 2'd2) ? 2'd0 : gnt + 2'd1;
  // A new pop lands next cycle, so the byte returning now must already be counted.
  assign credit   = ({1'b0, cnt} + {2'b00, rd_pend}) < 3'd3;
  assign rd_fire  = vld_gnt && credit &&
                    ((state == HDR) || (state == HLEN) || ((state == BODY) && (rem != 7'd0)));
  assign last_pop = (state == HLEN) ? (hdr_len == 6'd0) : (rem == 7'd1);

  assign read_enb_0 = rd_fire && (gnt == 2'd0);
  assign read_enb_1 = rd_fire && (gnt == 2'd1);
  assign read_enb_2 = rd_fire && (gnt == 2'd2);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      gnt      <= 2'd0;
      ptr      <= 2'd0;
      rem      <= 7'd0;
      busy_arb <= 1'b0;
      rd_pend  <= 1'b0;
      rd_sop   <= 1'b0;
      rd_eop   <= 1'b0;
    end else begin
      rd_pend <= rd_fire;
      rd_sop  <= rd_fire && (state == HDR);
      rd_eop  <= rd_fire && (state != HDR) && last_pop;
      case (state)
        IDLE: begin
          if ((|req) && credit) begin
            gnt      <= pick;
            state    <= HDR;
            busy_arb <= 1'b1;
          end
        end
        HDR: begin
          if (rd_fire) state <= HLEN;
        end
        HLEN: begin
          // len+1 remaining pops, minus the first body pop issued alongside
          rem <= {1'b0, hdr_len} + 7'd1 - {6'd0, rd_fire};
          if (rd_fire && last_pop) begin
            state    <= IDLE;
            busy_arb <= 1'b0;
            ptr      <= next_ptr;
          end else begin
            state <= BODY;
          end
        end
        BODY: begin
          if (rd_fire) begin
            rem <= rem - 7'd1;
            if (last_pop) begin
              state    <= IDLE;
              busy_arb <= 1'b0;
              ptr      <= next_ptr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push = rd_pend;
  assign pop  = m.m_valid && m.m_ready;

`ifdef ROUTER_ARB_PARITY_CHK_EN
  logic [7:0] acc;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc <= 8'h00;
    end else if (push) begin
      acc <= rd_sop ? rd_dat : (acc ^ rd_dat);
    end
  end
`endif

  always_comb begin
    push_ent      = '0;
    push_ent.dat  = rd_dat;
    push_ent.port = gnt;
    push_ent.sop  = rd_sop;
    push_ent.eop  = rd_eop;
`ifdef ROUTER_ARB_PARITY_CHK_EN
    push_ent.err  = rd_eop && (acc != rd_dat);
`endif
  end

  always_ff @(posedge clock) begin
    if (push) buf_q[wr_idx] <= push_ent;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_idx <= 2'd0;
      rd_idx <= 2'd0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_idx <= (wr_idx == 2'd2) ? 2'd0 : wr_idx + 2'd1;
      if (pop)  rd_idx <= (rd_idx == 2'd2) ? 2'd0 : rd_idx + 2'd1;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head      = buf_q[rd_idx];
  assign m.m_valid = (cnt != 2'd0);
  assign m.m_data  = m.m_valid ? head.dat  : 8'h00;
  assign m.m_sop   = m.m_valid && head.sop;
  assign m.m_eop   = m.m_valid && head.eop;
  assign m.m_port  = m.m_valid ? head.port : 2'd0;
`ifdef ROUTER_ARB_PARITY_CHK_EN
  assign m.m_err   = m.m_valid && head.err && head.eop;
`else
  assign m.m_err   = 1'b0;
`endif

endmodule

// File: tb/tb_router_out_arb.sv
// Scoreboard bench for router_out_arb: modelled router FIFOs feed packets, a negedge monitor checks every beat.
module tb_router_out_arb;
  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       vld_out_0 = 1'b0, vld_out_1 = 1'b0, vld_out_2 = 1'b0;
  logic [7:0] data_out_0 = 8'h00, data_out_1 = 8'h00, data_out_2 = 8'h00;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic       busy_arb;

  router_out_arb_if mif ();

  router_out_arb dut (
    .clock      (clock),
    .resetn     (resetn),
    .vld_out_0  (vld_out_0),
    .vld_out_1  (vld_out_1),
    .vld_out_2  (vld_out_2),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2),
    .read_enb_0 (read_enb_0),
    .read_enb_1 (read_enb_1),
    .read_enb_2 (read_enb_2),
    .busy_arb   (busy_arb),
    .m          (mif)
  );

  always #5 clock = ~clock;

  logic [7:0]  fq0[$], fq1[$], fq2[$];
  logic [12:0] exp_q[$];
  logic [2:0]  en = 3'b111;
  bit          sb_off = 1'b0;
  int          n_vec = 0;
  int          n_bad = 0;
  int          rd_tot = 0;
  int          xf_tot = 0;
  int          proto_viol = 0;
  int          max_occ = 0;
  int          rdc [3] = '{0, 0, 0};
  int          occ;
  logic [12:0] got;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input int p, input logic [7:0] b);
    case (p)
      0:       fq0.push_back(b);
      1:       fq1.push_back(b);
      default: fq2.push_back(b);
    endcase
  endtask

  // Header {len, addr=port}, len bytes base+0x11*i, then parity (XOR of all prior bytes, optionally corrupted).
  task automatic push_pkt(input int p, input int len, input logic [7:0] base, input bit bad, input bit exp_it);
    logic [7:0] hdr, b, par;
    logic [1:0] pp;
    logic       exp_err;
    pp  = p[1:0];
    hdr = {len[5:0], pp};
    par = hdr;
    put(p, hdr);
    if (exp_it) exp_q.push_back({1'b0, 1'b0, 1'b1, pp, hdr});
    for (int i = 0; i < len; i++) begin
      b   = base + 8'(i * 17);
      par = par ^ b;
      put(p, b);
      if (exp_it) exp_q.push_back({1'b0, 1'b0, 1'b0, pp, b});
    end
    if (bad) par = par ^ 8'h5A;
    put(p, par);
`ifdef ROUTER_ARB_PARITY_CHK_EN
    exp_err = bad;
`else
    exp_err = 1'b0;
`endif
    if (exp_it) exp_q.push_back({exp_err, 1'b1, 1'b0, pp, par});
  endtask

  task automatic wait_drain(input string nm);
    int g = 0;
    while ((exp_q.size() != 0 || busy_arb || mif.m_valid) && g < 300) begin
      @(negedge clock);
      g++;
    end
    chk({nm, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_busy"}, 32'(busy_arb), 32'd0);
  endtask

  // Router FIFO model: pop returns data next cycle, vld reflects post-pop occupancy.
  initial forever begin
    @(posedge clock);
    if (int'(read_enb_0) + int'(read_enb_1) + int'(read_enb_2) > 1) proto_viol <= proto_viol + 1;
    if (read_enb_0) begin
      if (fq0.size() > 0) data_out_0 <= fq0.pop_front(); else proto_viol <= proto_viol + 1;
      rdc[0] <= rdc[0] + 1;
    end
    if (read_enb_1) begin
      if (fq1.size() > 0) data_out_1 <= fq1.pop_front(); else proto_viol <= proto_viol + 1;
      rdc[1] <= rdc[1] + 1;
    end
    if (read_enb_2) begin
      if (fq2.size() > 0) data_out_2 <= fq2.pop_front(); else proto_viol <= proto_viol + 1;
      rdc[2] <= rdc[2] + 1;
    end
    vld_out_0 <= en[0] && (fq0.size() > 0);
    vld_out_1 <= en[1] && (fq1.size() > 0);
    vld_out_2 <= en[2] && (fq2.size() > 0);
    if (!resetn) begin
      rd_tot <= 0;
      xf_tot <= 0;
    end else begin
      rd_tot <= rd_tot + int'(read_enb_0 | read_enb_1 | read_enb_2);
      xf_tot <= xf_tot + int'(mif.m_valid && mif.m_ready);
    end
  end

  initial forever begin
    @(negedge clock);
    if (resetn && !sb_off) begin
      occ = rd_tot - xf_tot;
      if (occ > max_occ) max_occ = occ;
      if (mif.m_valid && mif.m_ready) begin
        got = {mif.m_err, mif.m_eop, mif.m_sop, mif.m_port, mif.m_data};
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL beat_extra: got %0h, required no beat", got);
        end else begin
          chk("beat", 32'(got), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int base_rd;
    int g;
    mif.m_ready = 1'b1;
    repeat (2) tick();
    chk("rst_stream", 32'({mif.m_valid, mif.m_sop, mif.m_eop, mif.m_err, mif.m_port, mif.m_data}), 32'd0);
    chk("rst_rd", 32'({read_enb_2, read_enb_1, read_enb_0}), 32'd0);
    chk("rst_busy", 32'(busy_arb), 32'd0);
    resetn = 1'b1;
    tick();

    // Port 1, len 3: idle latency and 5 pops
    base_rd = rdc[1];
    push_pkt(1, 3, 8'h11, 1'b0, 1'b1);
    @(posedge clock);
    @(negedge clock);
    chk("lat_c_rd", 32'(read_enb_1), 32'd0);
    @(negedge clock);
    chk("lat_c1_rd", 32'({read_enb_1, busy_arb}), 32'h3);
    @(negedge clock);
    chk("lat_c2_rd_valid", 32'({read_enb_1, mif.m_valid}), 32'h2);
    @(negedge clock);
    chk("lat_c3_sop", 32'({mif.m_valid, mif.m_sop, mif.m_data}), 32'h30D);
    wait_drain("t1");
    chk("t1_pulses", 32'(rdc[1] - base_rd), 32'd5);

    // Port 2 empties for 4 cycles mid-body while port 0 requests
    base_rd = rdc[2];
    push_pkt(2, 5, 8'hA0, 1'b0, 1'b1);
    g = 0;
    while (rdc[2] - base_rd < 3 && g < 50) begin tick(); g++; end
    en[2] = 1'b0;
    push_pkt(0, 1, 8'h5C, 1'b0, 1'b1);
    @(posedge clock);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("drop_hold", 32'({read_enb_0, read_enb_2, busy_arb}), 32'h1);
    end
    tick();
    en[2] = 1'b1;
    wait_drain("t2");

    // Sink stalls 6 cycles mid-payload on port 1
    base_rd = rdc[1];
    push_pkt(1, 8, 8'h30, 1'b0, 1'b1);
    g = 0;
    while (rdc[1] - base_rd < 4 && g < 50) begin tick(); g++; end
    mif.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clock);
    chk("bp_occupancy", 32'(rd_tot - xf_tot), 32'd3);
    chk("bp_rd_stop", 32'(read_enb_1), 32'd0);
    tick();
    mif.m_ready = 1'b1;
    wait_drain("t3");

    // Zero-length packet, then corrupted parity on port 0
    push_pkt(1, 0, 8'h00, 1'b0, 1'b1);
    wait_drain("t4");
    push_pkt(0, 2, 8'h77, 1'b1, 1'b1);
    wait_drain("t5");

    // Reset mid-body, then simultaneous requests must start from port 0
    sb_off = 1'b1;
    base_rd = rdc[2];
    push_pkt(2, 10, 8'h40, 1'b0, 1'b0);
    g = 0;
    while (rdc[2] - base_rd < 5 && g < 60) begin tick(); g++; end
    resetn = 1'b0;
    #1;
    chk("arst_stream", 32'({mif.m_valid, mif.m_sop, mif.m_eop, mif.m_err, mif.m_port, mif.m_data}), 32'd0);
    chk("arst_rd", 32'({read_enb_2, read_enb_1, read_enb_0}), 32'd0);
    chk("arst_busy", 32'(busy_arb), 32'd0);
    fq0.delete();
    fq1.delete();
    fq2.delete();
    repeat (3) tick();
    resetn = 1'b1;
    sb_off = 1'b0;
    tick();
    push_pkt(0, 2, 8'h01, 1'b0, 1'b1);
    push_pkt(1, 2, 8'h61, 1'b0, 1'b1);
    push_pkt(2, 2, 8'hC1, 1'b0, 1'b1);
    wait_drain("t6");

    chk("occ_max", 32'(max_occ), 32'd3);
    chk("proto_viol", 32'(proto_viol), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/router_out_arb.md
# router_out_arb

Output-side packet arbiter that merges the three router destination ports into one byte stream toward a single shared downstream consumer. It watches `vld_out_0..2`, drives `read_enb_0..2`, and moves whole packets (header, payload, parity) from one destination FIFO at a time, in round-robin order. It sits directly behind `router_top`, and its outputs feed a ready/valid sink.

## Interface
- No parameters. Packet format is fixed by the router: header = {len[5:0], addr[1:0]}, then len payload bytes, then 1 parity byte.
- `clock` input 1: single clock, rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `vld_out_0`, `vld_out_1`, `vld_out_2` input 1: destination FIFO non-empty.
- `data_out_0`, `data_out_1`, `data_out_2` input 8: FIFO read data, valid one cycle after `read_enb_x`.
- `read_enb_0`, `read_enb_1`, `read_enb_2` output 1: FIFO pops, at most one high per cycle.
- `m_data` output 8: merged stream byte.
- `m_valid` output 1: `m_data` valid.
- `m_ready` input 1: sink accepts; transfer when `m_valid && m_ready`.
- `m_sop` output 1: byte is a header.
- `m_eop` output 1: byte is a parity byte.
- `m_port` output 2: source port of current byte (0..2).
- `m_err` output 1: parity mismatch, valid with `m_eop`.
- `busy_arb` output 1: packet in progress (state != IDLE).

## Operation
- States:
  - IDLE: wait for any `vld_out_x`.
  - HDR: pop the header.
  - HLEN: capture len from returned data.
  - BODY: pop len+1 bytes.
- Grant:
  - In IDLE, if any `vld_out_x` is high and credit is available, pick the first requester at or after priority pointer `ptr` (order ptr, ptr+1, ptr+2, mod 3), register it in `gnt`, and go to HDR.
  - When BODY completes, set `ptr` = `gnt`+1 (2 wraps to 0).
- HDR: assert `read_enb_gnt` for one cycle when `vld_out_gnt` and credit are available. Otherwise stall in HDR. Then go to HLEN.
- HLEN: data_out_gnt holds the header. Load `rem` (7 bit) = len+1, push the header into the output buffer with sop=1, and go to BODY.
- BODY:
  - Each cycle with `vld_out_gnt` and credit: assert `read_enb_gnt` and decrement `rem`.
  - The data returned next cycle is pushed into the buffer. The last returned byte is tagged eop=1.
  - When `rem` reaches 0 after the final pop, return to IDLE. The final byte still arrives and is pushed in the next cycle.
- If `vld_out_gnt` is low in BODY (FIFO momentarily empty), hold `rem` and wait. Never switch ports mid-packet.
- len = 0 is legal: the packet is header plus parity only.
- Output buffer: 3-entry FIFO of {eop, sop, port, data}.
  - Credit is available when occupancy + reads in flight (0 or 1) < 3. This sustains 1 byte/cycle when `m_ready` stays high.
  - `m_valid` = buffer non-empty. The head entry drives `m_data`, `m_sop`, `m_eop` and `m_port`.
- `read_enb_x` is decoded from registered state, `gnt` and `vld_out_x`, and credit. It is never asserted for a non-granted port.
- Soft-reset hazard: the synchronizer flushes a FIFO whose `vld_out` stays high for 30 cycles without a read. The arbiter guarantees service only when `m_ready` is not held low for long. Starvation behaviour under sustained back-pressure is the system's responsibility.

## Timing
- Reset values: all `read_enb_x` = 0, `m_valid` = 0, `m_data` = 0, `m_sop` = `m_eop` = `m_err` = 0, `m_port` = 0, `busy_arb` = 0, `ptr` = 0, state IDLE, buffer empty.
- Idle latency, with `vld_out_x` first high in cycle C:
  - C+1: `read_enb_x` high (HDR).
  - C+2: header on data_out (HLEN), and the first body pop is issued.
  - C+3: `m_valid` with `m_sop`.
- Packet-to-packet: at least 1 IDLE cycle between the last pop of one packet and the header pop of the next.
- Asserting `resetn` mid-packet clears state and the buffer immediately. The bytes in flight are discarded.
- Simultaneous requests resolve in one cycle by `ptr`. A request that rises while BODY is active waits until IDLE.

## Configuration
- `ROUTER_ARB_PARITY_CHK_EN` defined:
  - XOR the header and payload bytes of each packet into an 8-bit accumulator.
  - On the parity byte, store (accumulator != parity byte) in the buffer entry's err field.
  - `m_err` = head err && `m_eop`.
- Undefined: no accumulator or err field, and `m_err` is tied 0.

## Test plan
- Reset, then packet on port 1 (header 8'h0D: len 3, addr 1; payload 11,22,33; parity) with `m_ready` = 1 → `read_enb_1` pulses 5 times. The sink sees 5 bytes with sop on 8'h0D, eop on parity, and `m_port` = 1 throughout. `ptr` becomes 2.
- `vld_out_0/1/2` all high in the same cycle, each FIFO holding a len-2 packet → packets delivered in order port 0, 1, 2, never interleaved.
- `m_ready` low for 6 cycles mid-payload → at most 3 bytes buffered, `read_enb` deasserted, no byte lost or duplicated after `m_ready` returns.
- `vld_out_2` drops for 4 cycles mid-body → arbiter holds `gnt` = 2 and `rem`, then resumes. The packet is complete and contiguous.
- `resetn` pulsed low during BODY → all outputs 0 asynchronously, and a new packet after reset is received cleanly starting at `ptr` = 0.
- With `ROUTER_ARB_PARITY_CHK_EN` defined, send a packet with a corrupted parity byte → `m_err` = 1 only on the eop beat. With the correct parity, `m_err` = 0.
